// File: rtl/hog_bin_acc.sv
// HOG orientation-bin accumulator.
// Each valid (magnitude, tan) sample is binned by gradient angle into one of
// nine 20-degree bins over 0..180 deg. Its magnitude is added to that bin's
// running sum. After CELL_PIX samples the full histogram is published on hist
// with a one-cycle o_valid pulse, and accumulation restarts for the next cell.
module hog_bin_acc #(
  parameter int MAG_W    = 13,
  parameter int TAN_I    = 4,
  parameter int TAN_F    = 16,
  parameter int N_BIN    = 9,
  parameter int CELL_PIX = 64,
  parameter int BIN_W    = MAG_W + $clog2(CELL_PIX)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  input  logic [MAG_W-1:0]       magnitude,
  input  logic [TAN_I+TAN_F-1:0] tan,
  output logic [N_BIN*BIN_W-1:0] hist,
  output logic                   o_valid
);

  localparam int TAN_W = TAN_I + TAN_F;
  localparam int IDX_W = $clog2(N_BIN);
  localparam int CNT_W = (CELL_PIX > 1) ? $clog2(CELL_PIX) : 1;

  // Rescale a Q4.16 threshold to the configured fraction width.
  function automatic logic [63:0] scale_t(input logic [63:0] t);
    if (TAN_F >= 16) return t << (TAN_F - 16);
    else             return t >> (16 - TAN_F);
  endfunction

  localparam logic [63:0] T20 = scale_t(64'd23853);
  localparam logic [63:0] T40 = scale_t(64'd54991);
  localparam logic [63:0] T60 = scale_t(64'd113512);
  localparam logic [63:0] T80 = scale_t(64'd371673);

  logic             neg;
  logic [TAN_W-1:0] abs_tan;
  logic [63:0]      abs_w;
  logic [IDX_W-1:0] lvl;
  logic [IDX_W-1:0] bin_d;

  logic             vld_q;
  logic [IDX_W-1:0] bin_q;
  logic [MAG_W-1:0] mag_q;

  logic [BIN_W-1:0]       acc_q [N_BIN];
  logic [BIN_W-1:0]       sum_d [N_BIN];
  logic [N_BIN*BIN_W-1:0] hist_d;
  logic [N_BIN*BIN_W-1:0] hist_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   o_valid_q;
  logic                   cell_done;

  // Angle binning: |tan| picks a distance from the horizontal axis, and the sign
  // mirrors it around bin 4. The most negative code negates to itself, which is
  // correct when read as unsigned and lands in bin 4.
  always_comb begin
    neg     = tan[TAN_W-1];
    abs_tan = neg ? -tan : tan;
    abs_w   = 64'(abs_tan);
    if (abs_w < T20)      lvl = IDX_W'(0);
    else if (abs_w < T40) lvl = IDX_W'(1);
    else if (abs_w < T60) lvl = IDX_W'(2);
    else if (abs_w < T80) lvl = IDX_W'(3);
    else                  lvl = IDX_W'(4);
    bin_d = neg ? IDX_W'(N_BIN - 1) - lvl : lvl;
  end

  // Stage 1: register the bin index, the magnitude and the sample valid.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= 1'b0;
      bin_q <= '0;
      mag_q <= '0;
    end else begin
      vld_q <= i_valid;
      if (i_valid) begin
        bin_q <= bin_d;
        mag_q <= magnitude;
      end
    end
  end

  // Per-bin sums including the staged sample, and the flattened histogram view.
  always_comb begin
    hist_d = '0;
    for (int b = 0; b < N_BIN; b++) begin
      sum_d[b] = acc_q[b];
      if (vld_q && (bin_q == IDX_W'(b))) sum_d[b] = acc_q[b] + BIN_W'(mag_q);
      hist_d[b*BIN_W +: BIN_W] = sum_d[b];
    end
  end

  assign cell_done = vld_q && (cnt_q == CNT_W'(CELL_PIX - 1));

  // Stage 2: accumulate. On the last sample of a cell the final sums go straight
  // to hist and the accumulators restart at zero, so no cycle is lost.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int b = 0; b < N_BIN; b++) acc_q[b] <= '0;
      hist_q    <= '0;
      cnt_q     <= '0;
      o_valid_q <= 1'b0;
    end else begin
      for (int b = 0; b < N_BIN; b++) acc_q[b] <= cell_done ? '0 : sum_d[b];
      if (cell_done) hist_q <= hist_d;
      if (cell_done)  cnt_q <= '0;
      else if (vld_q) cnt_q <= cnt_q + CNT_W'(1);
      o_valid_q <= cell_done;
    end
  end

  assign hist    = hist_q;
  assign o_valid = o_valid_q;

endmodule

// File: tb/tb_hog_bin_acc.sv
// Directed bench for hog_bin_acc: reset, single cell, threshold boundaries,
// back-to-back cells, gapped input and mid-cell reset.
module tb_hog_bin_acc;

  localparam int MAG_W = 13;
  localparam int TAN_W = 20;
  localparam int N_BIN = 9;
  localparam int BIN_W = 19;
  localparam int HW    = N_BIN * BIN_W;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             i_valid = 1'b0;
  logic [MAG_W-1:0] magnitude = '0;
  logic [TAN_W-1:0] tan = '0;
  logic [HW-1:0]    hist;
  logic             o_valid;

  always #5 clk = ~clk;

  hog_bin_acc dut (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (i_valid),
    .magnitude(magnitude),
    .tan      (tan),
    .hist     (hist),
    .o_valid  (o_valid)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ov_cnt = 0;
  int last_cyc = 0;
  logic [HW-1:0] hist_log [16];
  int            cyc_log  [16];

  // Cycle counter and o_valid log, sampled mid-cycle.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (o_valid) begin
      hist_log[ov_cnt % 16] <= hist;
      cyc_log[ov_cnt % 16]  <= cyc + 1;
      ov_cnt                <= ov_cnt + 1;
    end
  end

  task automatic drive(input logic v, input logic [MAG_W-1:0] m, input logic [TAN_W-1:0] t);
    @(posedge clk);
    #1;
    i_valid   = v;
    magnitude = m;
    tan       = t;
    if (v) last_cyc = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, '0);
  endtask

  task automatic chk(input string tag, input logic [HW-1:0] obs, input logic [HW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [HW-1:0] hv(input int b, input int v);
    logic [HW-1:0] r;
    logic [31:0]   vv;
    r  = '0;
    vv = v;
    r[b*BIN_W +: BIN_W] = vv[BIN_W-1:0];
    return r;
  endfunction

  logic [TAN_W-1:0] bnd_tan [7];
  logic [TAN_W-1:0] bin_tan [9];
  logic [HW-1:0]    exp_h;
  int               b0;
  int               last_a;

  initial begin
    bnd_tan = '{20'd23852, 20'd23853, -20'sd23853, 20'd371673, -20'sd371673,
                20'h80000, 20'h7FFFF};
    bin_tan = '{20'd0, 20'd30000, 20'd80000, 20'd200000, 20'd400000,
                -20'sd200000, -20'sd80000, -20'sd30000, -20'sd1000};

    // Reset state
    idle(3);
    chk("rst_ovalid", HW'(o_valid), HW'(0));
    chk("rst_hist", hist, '0);
    rst = 1'b1;

    // Single cell: tan=0, magnitude 16
    b0 = ov_cnt;
    repeat (64) drive(1'b1, 13'd16, 20'd0);
    idle(4);
    chk("c1_count", HW'(ov_cnt - b0), HW'(1));
    chk("c1_latency", HW'(cyc_log[b0 % 16]), HW'(last_cyc + 2));
    chk("c1_pulse_hist", hist_log[b0 % 16], hv(0, 1024));
    chk("c1_hist_hold", hist, hv(0, 1024));
    chk("c1_ovalid_low", HW'(o_valid), HW'(0));

    // Threshold boundary codes
    b0 = ov_cnt;
    for (int i = 0; i < 7; i++) drive(1'b1, 13'd1, bnd_tan[i]);
    repeat (57) drive(1'b1, 13'd0, 20'd0);
    idle(4);
    exp_h = hv(0, 1) | hv(1, 1) | hv(4, 4) | hv(7, 1);
    chk("bnd_count", HW'(ov_cnt - b0), HW'(1));
    chk("bnd_hist", hist, exp_h);

    // Back-to-back cells
    b0 = ov_cnt;
    repeat (64) drive(1'b1, 13'd8191, 20'hFFFFF);
    last_a = last_cyc;
    repeat (64) drive(1'b1, 13'd1, 20'd0);
    idle(4);
    chk("b2b_count", HW'(ov_cnt - b0), HW'(2));
    chk("b2b_latency_a", HW'(cyc_log[b0 % 16]), HW'(last_a + 2));
    chk("b2b_spacing", HW'(cyc_log[(b0 + 1) % 16] - cyc_log[b0 % 16]), HW'(64));
    chk("b2b_hist_a", hist_log[b0 % 16], hv(8, 524224));
    chk("b2b_hist_b", hist_log[(b0 + 1) % 16], hv(0, 64));

    // Gapped input with junk on idle cycles; one sample per bin in rotation
    b0 = ov_cnt;
    for (int i = 0; i < 64; i++) begin
      repeat ($urandom_range(0, 2)) drive(1'b0, MAG_W'($urandom), TAN_W'($urandom));
      drive(1'b1, 13'd3, bin_tan[i % 9]);
    end
    idle(4);
    exp_h = hv(0, 24);
    for (int b = 1; b < 9; b++) exp_h = exp_h | hv(b, 21);
    chk("gap_count", HW'(ov_cnt - b0), HW'(1));
    chk("gap_latency", HW'(cyc_log[b0 % 16]), HW'(last_cyc + 2));
    chk("gap_hist", hist, exp_h);

    // Mid-cell reset, with sample 30 still in the pipeline
    b0 = ov_cnt;
    repeat (30) drive(1'b1, 13'd5, 20'd0);
    drive(1'b0, '0, '0);
    rst = 1'b0;
    drive(1'b0, '0, '0);
    rst = 1'b1;
    chk("mrst_hist", hist, '0);
    chk("mrst_ovalid", HW'(o_valid), HW'(0));
    repeat (64) drive(1'b1, 13'd2, 20'd113512);
    idle(4);
    chk("mrst_count", HW'(ov_cnt - b0), HW'(1));
    chk("mrst_latency", HW'(cyc_log[b0 % 16]), HW'(last_cyc + 2));
    chk("mrst_hist_final", hist, hv(3, 128));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hog_bin_acc.md
HOG_BIN_ACC -- requirements
Module: hog_bin_acc

Interface
REQ-001 SHALL have parameter MAG_W, default 13, meaning magnitude width, unsigned Q9.4.
REQ-002 SHALL have parameter TAN_I, default 4, meaning tan integer bits including sign.
REQ-003 SHALL have parameter TAN_F, default 16, meaning tan fraction bits.
REQ-004 SHALL have parameter N_BIN, default 9, meaning orientation bins of 20 deg each over 0..180 deg.
REQ-005 SHALL have parameter CELL_PIX, default 64, meaning samples per cell (8x8); power of two.
REQ-006 SHALL have parameter BIN_W, default MAG_W+log2(CELL_PIX) = 19, meaning per-bin accumulator width.
REQ-007 SHALL have port clk, input, 1, rising-edge clock.
REQ-008 SHALL have port rst, input, 1; reset rst, synchronous, active-low.
REQ-009 SHALL have port i_valid, input, 1, meaning magnitude/tan sample valid this cycle.
REQ-010 SHALL have port magnitude, input, MAG_W, meaning gradient magnitude.
REQ-011 SHALL have port tan, input, TAN_I+TAN_F, meaning signed two's-complement tan(theta), Q4.16.
REQ-012 SHALL have port hist, output, N_BIN*BIN_W, meaning cell histogram; bin0 in LSBs, bin8 in MSBs.
REQ-013 SHALL have port o_valid, output, 1, meaning one-cycle pulse: hist holds a complete cell.

Function
REQ-014 SHALL use Q4.16 thresholds T20=23853, T40=54991, T60=113512, T80=371673 (tan 20/40/60/80 deg), each shifted left by TAN_F-16 when TAN_F differs from 16.
REQ-015 SHALL, for tan >= 0, select bin 0 if tan<T20, bin 1 if <T40, bin 2 if <T60, bin 3 if <T80, else bin 4.
REQ-016 SHALL, for tan < 0 with a=-tan, select bin 8 if a<T20, bin 7 if <T40, bin 6 if <T60, bin 5 if <T80, else bin 4.
REQ-017 SHALL treat comparisons as strict less-than; a value equal to a threshold goes to the bin farther from bin 0/8.
REQ-018 SHALL compute -tan of the most negative code (0x80000) as 0x80000 unsigned, giving bin 4.
REQ-019 SHALL register bin index, magnitude and valid in stage 1 (cycle after i_valid).
REQ-020 SHALL, in stage 2, add the staged magnitude to the selected bin accumulator; other bins unchanged.
REQ-021 SHALL count accepted samples modulo CELL_PIX with a counter advancing only on stage-1 valid.
REQ-022 SHALL, when the CELL_PIX-th sample is accumulated, load hist with all final sums (including that sample) and assert o_valid the next cycle, i.e. two cycles after the last sample's i_valid.
REQ-023 SHALL, in that same cycle, clear every accumulator and the counter, so a sample arriving back-to-back starts the next cell from zero with no lost cycle.
REQ-024 SHALL hold hist stable between o_valid pulses; o_valid high exactly one cycle per cell.
REQ-025 SHALL ignore magnitude/tan when i_valid is low; gaps in i_valid do not affect sums or counts.
REQ-026 SHALL not overflow: BIN_W suffices for CELL_PIX samples at maximum magnitude; no saturation logic.
REQ-027 SHALL have no back-pressure; one sample accepted per cycle whenever i_valid is high.

Reset
REQ-028 SHALL, while rst is low at a clock edge, clear o_valid, hist, all accumulators, sample counter and pipeline valids to 0.
REQ-029 SHALL discard a partially accumulated cell on reset; the first sample after rst returns high is sample 1 of a new cell.
REQ-030 SHALL not produce o_valid for samples whose pipeline stage was occupied during reset.

Verification
REQ-031 SHALL pass: 64 consecutive samples, tan=0, magnitude=16 -> one o_valid two cycles after the 64th; bin0=1024, all others 0.
REQ-032 SHALL pass: boundary codes tan=23852, 23853, -23853, 371673, -371673, 0x80000, 0x7FFFF, magnitude=1 each, padded with 57 samples of tan=0 mag=0 -> bins 0,1,7,4,4,4,4 incremented; final bin0=1, bin1=1, bin4=4, bin7=1.
REQ-033 SHALL pass: two cells back-to-back, cell A all magnitude 8191 tan=-1, cell B all magnitude 1 tan=0 -> o_valid 64 cycles apart; A bin8=524224; B bin0=64, bin8=0.
REQ-034 SHALL pass: 64 samples interleaved with random i_valid-low gaps -> identical hist to gap-free run; o_valid 2 cycles after last valid sample.
REQ-035 SHALL pass: rst low for 1 cycle after 30 samples, then 64 samples of tan=T60 mag=2 -> no o_valid before the 64 post-reset samples; bin3=128, others 0.
